// File: rtl/compass_pkg.sv
// Shared constants and types for the seven-segment scanner: segment patterns,
// scan slot enumeration and the packed three-digit BCD value.
package compass_pkg;

  localparam int NUM_SCAN_SLOTS = 4;

  // Active-low cathode patterns, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    SLOT_ONES     = 2'd0,
    SLOT_TENS     = 2'd1,
    SLOT_HUNDREDS = 2'd2,
    SLOT_BLANK    = 2'd3
  } slot_e;

  typedef struct packed {
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd3_t;

endpackage

// File: rtl/seven_seg_scan_if.sv
// Bundle between the BCD source / display pins and the scanner, plus debug
// visibility of the scan slot and the pending snapshot flag.
interface seven_seg_scan_if;
  import compass_pkg::*;

  // load is a valid-only strobe: the scanner is always ready, so every cycle
  // with load=1 is accepted and the last accepted value in a frame wins.
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       load;
  logic       blank_lz;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] an;
  logic       frame_done;
  slot_e      dbg_slot;
  logic       dbg_pending_valid;

  modport slave (
    input  hundreds, tens, ones, load, blank_lz,
    output seg, dp, an, frame_done, dbg_slot, dbg_pending_valid
  );

  modport master (
    output hundreds, tens, ones, load, blank_lz,
    input  seg, dp, an, frame_done, dbg_slot, dbg_pending_valid
  );

endinterface

// File: rtl/seven_seg_scan_bcd_to_seg.sv
// Combinational BCD digit to active-low segment pattern; values 10..15 show a
// dash and are never blanked.
module bcd_to_seg
  import compass_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (digit_i > 4'd9) begin
      seg_o = SEG_DASH;
    end else if (blank_i) begin
      seg_o = SEG_BLANK;
    end else begin
      unique case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        default: seg_o = SEG_9;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed 3-digit seven-segment scanner with per-slot anti-ghost blanking,
// tear-free frame-boundary digit updates and leading-zero suppression.
module seven_seg_scan
  import compass_pkg::*;
#(
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 1000
) (
  input  logic           clk,
  input  logic           reset,
  seven_seg_scan_if.slave bus
);

  localparam int TW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;

  logic [TW-1:0] tick_q, tick_d;
  slot_e         slot_q, slot_d;
  bcd3_t         pend_q, pend_d;
  bcd3_t         disp_q, disp_d;
  logic          pend_valid_q, pend_valid_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          fd_q, fd_d;

  logic          tick_wrap;
  logic          frame_wrap;
  bcd3_t         in_bcd;
  logic [3:0]    cur_digit;
  logic          cur_blank;
  logic          hund_blank;
  logic          tens_blank;
  logic [6:0]    enc_seg;

  assign in_bcd     = '{hundreds: bus.hundreds, tens: bus.tens, ones: bus.ones};
  assign tick_wrap  = (tick_q == TW'(DIGIT_TICKS - 1));
  assign frame_wrap = tick_wrap && (slot_q == SLOT_BLANK);

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q       <= '0;
      slot_q       <= SLOT_ONES;
      pend_q       <= '0;
      disp_q       <= '0;
      pend_valid_q <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= 4'hF;
      fd_q         <= 1'b0;
    end else begin
      tick_q       <= tick_d;
      slot_q       <= slot_d;
      pend_q       <= pend_d;
      disp_q       <= disp_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      fd_q         <= fd_d;
    end
  end

  // Scan sequencer: the slot only moves when the per-slot tick counter wraps.
  always_comb begin
    tick_d = tick_wrap ? '0 : tick_q + 1'b1;
    slot_d = slot_q;
    if (tick_wrap) begin
      unique case (slot_q)
        SLOT_ONES:     slot_d = SLOT_TENS;
        SLOT_TENS:     slot_d = SLOT_HUNDREDS;
        SLOT_HUNDREDS: slot_d = SLOT_BLANK;
        default:       slot_d = SLOT_ONES;
      endcase
    end
  end

  // Snapshot: a load at the frame edge bypasses pending so it is shown at once.
  always_comb begin
    pend_d       = pend_q;
    disp_d       = disp_q;
    pend_valid_d = pend_valid_q;
    if (bus.load) begin
      pend_d = in_bcd;
    end
    if (frame_wrap) begin
      pend_valid_d = 1'b0;
      if (bus.load) begin
        disp_d = in_bcd;
      end else if (pend_valid_q) begin
        disp_d = pend_q;
      end
    end else if (bus.load) begin
      pend_valid_d = 1'b1;
    end
  end

  always_comb begin
    hund_blank = bus.blank_lz && (disp_q.hundreds == 4'd0);
    tens_blank = hund_blank && (disp_q.tens == 4'd0);
    cur_digit  = 4'd0;
    cur_blank  = 1'b1;
    unique case (slot_q)
      SLOT_ONES: begin
        cur_digit = disp_q.ones;
        cur_blank = 1'b0;
      end
      SLOT_TENS: begin
        cur_digit = disp_q.tens;
        cur_blank = tens_blank;
      end
      SLOT_HUNDREDS: begin
        cur_digit = disp_q.hundreds;
        cur_blank = hund_blank;
      end
      default: begin
        cur_digit = 4'd0;
        cur_blank = 1'b1;
      end
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .digit_i (cur_digit),
    .blank_i (cur_blank),
    .seg_o   (enc_seg)
  );

  always_comb begin
    seg_d = enc_seg;
    an_d  = 4'hF;
    if (tick_q >= TW'(BLANK_TICKS)) begin
      an_d = ~(4'b0001 << slot_q);
    end
    fd_d = frame_wrap;
  end

  assign bus.seg               = seg_q;
  assign bus.an                = {4'hF, an_q};
  assign bus.dp                = 1'b1;
  assign bus.frame_done        = fd_q;
  assign bus.dbg_slot          = slot_q;
  assign bus.dbg_pending_valid = pend_valid_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: frame-level model of what each scan cycle must
// show, checked every cycle, plus hand-computed literal spot checks.
module tb_seven_seg_scan;
  import compass_pkg::*;

  localparam int DT    = 8;
  localparam int BT    = 2;
  localparam int FRAME = DT * NUM_SCAN_SLOTS;

  logic clk = 1'b0;
  logic reset = 1'b1;

  seven_seg_scan_if bus ();

  seven_seg_scan #(
    .DIGIT_TICKS (DT),
    .BLANK_TICKS (BT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- model state ----------------
  // sn: scan-cycle number since reset release that the DUT is in now.
  int          sn = 0;
  bit          started = 1'b0;
  bit          last_edge_reset = 1'b1;
  int          prev_n = 0;
  bit          prev_blz = 1'b0;
  int          load_cyc_q[$];
  logic [11:0] exp_q[$];

  function automatic logic [6:0] enc(logic [3:0] d);
    logic [6:0] table_v [16];
    table_v = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    return table_v[d];
  endfunction

  // Value on display during cycle n: last load taken on or before the final
  // cycle of the previous frame; nothing loaded means zero.
  function automatic logic [11:0] shown(int n);
    int limit;
    logic [11:0] v;
    limit = (n / FRAME) * FRAME - 1;
    v = 12'h000;
    foreach (load_cyc_q[i]) begin
      if (load_cyc_q[i] <= limit) v = exp_q[i];
    end
    return v;
  endfunction

  function automatic logic [6:0] model_seg(int n, bit blz);
    logic [11:0] v;
    logic [3:0]  h, t, o;
    bit          hb, tb;
    int          slot;
    v = shown(n);
    h = v[11:8];
    t = v[7:4];
    o = v[3:0];
    hb = blz && (h == 4'd0);
    tb = hb && (t == 4'd0);
    slot = (n / DT) % NUM_SCAN_SLOTS;
    case (slot)
      0:       return enc(o);
      1:       return tb ? 7'h7F : enc(t);
      2:       return hb ? 7'h7F : enc(h);
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [7:0] model_an(int n);
    logic [7:0] a;
    a = 8'hFF;
    if ((n % DT) >= BT) a[(n / DT) % NUM_SCAN_SLOTS] = 1'b0;
    return a;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      last_edge_reset = 1'b1;
      sn = 0;
      load_cyc_q.delete();
      exp_q.delete();
    end else begin
      last_edge_reset = 1'b0;
      prev_n = sn;
      prev_blz = bus.blank_lz;
      if (bus.load) begin
        load_cyc_q.push_back(sn);
        exp_q.push_back({bus.hundreds, bus.tens, bus.ones});
      end
      sn++;
    end
    started = 1'b1;
  end

  // ---------------- scoreboard ----------------
  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      if (last_edge_reset) begin
        chk("seg_rst", 8'(bus.seg), 8'h7F);
        chk("an_rst", bus.an, 8'hFF);
        chk("fd_rst", 8'(bus.frame_done), 8'h00);
      end else begin
        chk("seg", 8'(bus.seg), 8'(model_seg(prev_n, prev_blz)));
        chk("an", bus.an, model_an(prev_n));
        chk("frame_done", 8'(bus.frame_done), 8'((prev_n % FRAME) == FRAME - 1));
      end
      chk("dp", 8'(bus.dp), 8'h01);
      chk("dbg_slot", 8'(bus.dbg_slot), 8'((sn / DT) % NUM_SCAN_SLOTS));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_n(int target);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      if (!last_edge_reset && prev_n == target) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_n: scan cycle %0d never observed", target);
    end
    #1;
  endtask

  task automatic lit(string nm, logic [6:0] es, logic [7:0] ea);
    chk({nm, "_seg"}, 8'(bus.seg), 8'(es));
    chk({nm, "_an"}, bus.an, ea);
  endtask

  task automatic wait_sn(int target);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(posedge clk);
      #2;
      if (sn == target) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_sn: scan cycle %0d never reached", target);
    end
  endtask

  // Drives one load strobe; returns the scan cycle it was taken in.
  task automatic drive_load(logic [3:0] h, logic [3:0] t, logic [3:0] o, output int cyc);
    @(posedge clk);
    #2;
    bus.hundreds = h;
    bus.tens     = t;
    bus.ones     = o;
    bus.load     = 1'b1;
    cyc          = sn;
    @(posedge clk);
    #2;
    bus.load = 1'b0;
  endtask

  task automatic drive_load_at(int target, logic [3:0] h, logic [3:0] t, logic [3:0] o);
    wait_sn(target);
    bus.hundreds = h;
    bus.tens     = t;
    bus.ones     = o;
    bus.load     = 1'b1;
    @(posedge clk);
    #2;
    bus.load = 1'b0;
  endtask

  function automatic int next_base(int c);
    return (c / FRAME + 1) * FRAME;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int c, nb, f;
    bus.hundreds = 4'd0;
    bus.tens     = 4'd0;
    bus.ones     = 4'd0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;
    reset        = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;

    // Power-up shows 0 in slot 0 once its blanking window ends.
    wait_n(1);
    lit("boot_t1", 7'h40, 8'hFF);
    wait_n(2);
    lit("boot_t2", 7'h40, 8'hFE);
    wait_n(31);
    chk("boot_fd", 8'(bus.frame_done), 8'h01);

    // 3/5/9 without leading-zero blanking.
    drive_load(4'd3, 4'd5, 4'd9, c);
    nb = next_base(c);
    wait_n(nb + 1);  lit("359_s0_blank", 7'h10, 8'hFF);
    wait_n(nb + 2);  lit("359_s0", 7'h10, 8'hFE);
    wait_n(nb + 9);  lit("359_s1_blank", 7'h12, 8'hFF);
    wait_n(nb + 10); lit("359_s1", 7'h12, 8'hFD);
    wait_n(nb + 18); lit("359_s2", 7'h30, 8'hFB);
    wait_n(nb + 26); lit("359_s3", 7'h7F, 8'hF7);

    // Leading-zero blanking.
    bus.blank_lz = 1'b1;
    drive_load(4'd0, 4'd0, 4'd7, c);
    nb = next_base(c);
    wait_n(nb + 2);  lit("007_s0", 7'h78, 8'hFE);
    wait_n(nb + 10); lit("007_s1", 7'h7F, 8'hFD);
    wait_n(nb + 18); lit("007_s2", 7'h7F, 8'hFB);
    drive_load(4'd0, 4'd5, 4'd0, c);
    nb = next_base(c);
    wait_n(nb + 2);  lit("050_s0", 7'h40, 8'hFE);
    wait_n(nb + 10); lit("050_s1", 7'h12, 8'hFD);
    wait_n(nb + 18); lit("050_s2", 7'h7F, 8'hFB);

    // Mid-frame load superseded by a load in the boundary cycle.
    bus.blank_lz = 1'b0;
    f = next_base(sn);
    drive_load_at(f + 10, 4'd1, 4'd2, 4'd3);
    drive_load_at(f + 31, 4'd4, 4'd5, 4'd6);
    wait_n(f + 31);  chk("boundary_fd", 8'(bus.frame_done), 8'h01);
    wait_n(f + 34);  lit("456_s0", 7'h02, 8'hFE);
    wait_n(f + 42);  lit("456_s1", 7'h12, 8'hFD);
    wait_n(f + 50);  lit("456_s2", 7'h19, 8'hFB);

    // Dash digit defeats blanking; then reset mid-frame with a colliding load.
    bus.blank_lz = 1'b1;
    drive_load(4'd0, 4'hC, 4'd1, c);
    nb = next_base(c);
    wait_n(nb + 10); lit("0c1_s1", 7'h3F, 8'hFD);
    wait_n(nb + 18); lit("0c1_s2", 7'h7F, 8'hFB);
    wait_sn(nb + 20);
    reset        = 1'b1;
    bus.load     = 1'b1;
    bus.hundreds = 4'd9;
    bus.tens     = 4'd9;
    bus.ones     = 4'd9;
    @(posedge clk);
    #2;
    lit("rst_mid", 7'h7F, 8'hFF);
    chk("rst_mid_slot", 8'(bus.dbg_slot), 8'h00);
    chk("rst_mid_fd", 8'(bus.frame_done), 8'h00);
    reset    = 1'b0;
    bus.load = 1'b0;
    wait_n(2);  lit("post_rst_s0", 7'h40, 8'hFE);
    wait_n(10); lit("post_rst_s1", 7'h7F, 8'hFD);
    wait_n(34); lit("post_rst_f1_s0", 7'h40, 8'hFE);

    // Random loads and blanking changes, checked by the per-cycle model.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(1, 40)) @(posedge clk);
      bus.blank_lz = 1'($urandom_range(0, 1));
      drive_load(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), c);
    end
    repeat (3 * FRAME) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
